led_bank_arbiter: RTL and testbench

//  Shares the board's 5-LED bank (RLED1..RLED4, GLED5) between N_REQ pattern generators.

---
 rtl/led_bank_arbiter.sv | 152 +++++++++++++++
 tb/tb_led_bank_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 5-LED bank shared by N_REQ pattern generators, with
// the free-running slow-tick divider that paces minimum hold time and the requesters.
module led_bank_arbiter #(
  parameter int                   N_REQ        = 3,
  parameter int                   DIV_WIDTH    = 25,
  parameter logic [DIV_WIDTH-1:0] DIV_MAX      = DIV_WIDTH'(24'hFFFFFF),
  parameter int                   HOLD_TICKS   = 4,
  parameter logic [4:0]           IDLE_PATTERN = 5'b00000
) (
  input  logic               CLK_IN,
  input  logic               RST_IN,
  input  logic [N_REQ-1:0]   REQ_IN,
  input  logic [5*N_REQ-1:0] PAT_IN,
  output logic [N_REQ-1:0]   GNT_OUT,
  output logic               TICK_OUT,
  output logic               RLED1,
  output logic               RLED2,
  output logic               RLED3,
  output logic               RLED4,
  output logic               GLED5
);

  localparam int IDX_W     = $clog2(N_REQ);
  localparam int HOLD_W    = $clog2(HOLD_TICKS + 1);
  localparam int PAT_SLOTS = 1 << IDX_W;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 tick_reg;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [N_REQ-1:0]     gnt_reg, gnt_next;
  logic [4:0]           leds_reg, leds_next;
  logic [4:0]           pat_arr [PAT_SLOTS];
  logic [IDX_W:0]       idle_pick, pre_pick;

  // Unused slots of the power-of-two pattern table read as idle.
  generate
    for (genvar gi = 0; gi < PAT_SLOTS; gi++) begin : g_pat
      if (gi < N_REQ) begin : g_used
        assign pat_arr[gi] = PAT_IN[5*gi +: 5];
      end else begin : g_unused
        assign pat_arr[gi] = IDLE_PATTERN;
      end
    end
  endgenerate

  // Returns {found, index}: first set request among span slots starting at start, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input int start, input int span);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] sel;
    int               idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = IDX_W'(idx);
      if (k < span && req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (div_reg == DIV_MAX);
      div_reg  <= (div_reg == DIV_MAX) ? '0 : div_reg + 1'b1;
    end
  end

  assign idle_pick = rr_pick(REQ_IN, int'(rr_ptr_reg), N_REQ);
  assign pre_pick  = rr_pick(REQ_IN, int'(owner_reg) + 1, N_REQ - 1);

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    hold_next   = hold_reg;
    gnt_next    = gnt_reg;
    leds_next   = IDLE_PATTERN;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (idle_pick[IDX_W]) begin
          state_next = GRANT;
          owner_next = idle_pick[IDX_W-1:0];
          gnt_next   = N_REQ'(1) << idle_pick[IDX_W-1:0];
          hold_next  = '0;
        end
      end
      GRANT: begin
        // Release takes priority over a same-cycle preemption.
        if (!REQ_IN[owner_reg]) begin
          state_next  = IDLE;
          gnt_next    = '0;
          rr_ptr_next = inc_mod(owner_reg);
        end else begin
          leds_next = pat_arr[owner_reg];
          if (tick_reg) begin
            if (hold_reg < HOLD_MAX) begin
              hold_next = hold_reg + 1'b1;
            end else if (pre_pick[IDX_W]) begin
              owner_next  = pre_pick[IDX_W-1:0];
              gnt_next    = N_REQ'(1) << pre_pick[IDX_W-1:0];
              hold_next   = '0;
              rr_ptr_next = inc_mod(pre_pick[IDX_W-1:0]);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      hold_reg   <= '0;
      gnt_reg    <= '0;
      leds_reg   <= IDLE_PATTERN;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      hold_reg   <= hold_next;
      gnt_reg    <= gnt_next;
      leds_reg   <= leds_next;
    end
  end

  assign GNT_OUT  = gnt_reg;
  assign TICK_OUT = tick_reg;
  assign RLED1    = leds_reg[0];
  assign RLED2    = leds_reg[1];
  assign RLED3    = leds_reg[2];
  assign RLED4    = leds_reg[3];
  assign GLED5    = leds_reg[4];

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random traffic, all checked
// against a cycle-level reference model built from the arbitration rules.
module tb_led_bank_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [14:0] pat = '0;
  logic [2:0]  gnt;
  logic        tick;
  logic        r1, r2, r3, r4, g5;
  logic [4:0]  leds_obs;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  int         m_owner = -1;
  int         m_hold  = 0;
  int         m_ptr   = 0;
  int         m_cyc   = 0;
  logic [4:0] m_leds  = '0;
  logic [2:0] exp_gnt = '0;
  logic       exp_tick = 1'b0;

  led_bank_arbiter #(
    .N_REQ(3), .DIV_WIDTH(25), .DIV_MAX(25'd3), .HOLD_TICKS(2), .IDLE_PATTERN(5'b00000)
  ) dut (
    .CLK_IN(clk), .RST_IN(rst), .REQ_IN(req), .PAT_IN(pat),
    .GNT_OUT(gnt), .TICK_OUT(tick),
    .RLED1(r1), .RLED2(r2), .RLED3(r3), .RLED4(r4), .GLED5(g5)
  );

  assign leds_obs = {g5, r4, r3, r2, r1};

  always #5 clk = ~clk;

  // Divider phase is pure arithmetic on cycles since reset: a tick appears every 4th cycle.
  function automatic logic tick_at(input int c);
    return (c >= 4) && (c % 4 == 0);
  endfunction

  function automatic logic req_bit(input logic [2:0] r, input int i);
    logic [2:0] s;
    s = r >> i;
    return s[0];
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic step();
    logic       tnow;
    logic [4:0] nl;
    logic [14:0] sh;
    int         w;
    tnow = tick_at(m_cyc);
    if (rst) begin
      m_cyc = 0; m_owner = -1; m_hold = 0; m_ptr = 0; m_leds = '0;
    end else begin
      nl = 5'b00000;
      if (m_owner < 0) begin
        w = -1;
        for (int k = N - 1; k >= 0; k--)
          if (req_bit(req, (m_ptr + k) % N)) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_owner = w; m_hold = 0;
        end
      end else if (!req_bit(req, m_owner)) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        sh = pat >> (5 * m_owner);
        nl = sh[4:0];
        if (tnow) begin
          if (m_hold < 2) begin
            m_hold++;
          end else begin
            w = -1;
            for (int k = N - 1; k >= 1; k--)
              if (req_bit(req, (m_owner + k) % N)) w = (m_owner + k) % N;
            if (w >= 0) begin
              m_owner = w; m_hold = 0; m_ptr = (w + 1) % N;
            end
          end
        end
      end
      m_leds = nl;
      m_cyc++;
    end
    exp_gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    exp_tick = tick_at(m_cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b111;
    pat = 15'h7FFF;
    do_reset(2);
    vectors++;
    if (gnt !== 3'b000 || tick !== 1'b0 || leds_obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset: gnt/tick/led got %b/%b/%b want 000/0/00000", gnt, tick, leds_obs);
    end
    $display("reset: gnt=%b tick=%b leds=%b", gnt, tick, leds_obs);
  endtask

  task automatic test_single_req();
    req = 3'b000;
    pat = {5'b00000, 5'b10101, 5'b01010};
    do_reset(2);
    req = 3'b010;
    step();
    vectors++;
    if (gnt !== 3'b010 || leds_obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL single_gnt: gnt/led got %b/%b want 010/00000", gnt, leds_obs);
    end
    step();
    vectors++;
    if (gnt !== 3'b010 || leds_obs !== 5'b10101) begin
      miscompares++;
      $display("FAIL single_led: gnt/led got %b/%b want 010/10101", gnt, leds_obs);
    end
    $display("single: gnt=%b leds=%b", gnt, leds_obs);
  endtask

  task automatic test_round_robin();
    logic [2:0] seen [4];
    logic [2:0] want [4];
    logic [2:0] prev;
    int         n_seen;
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
    n_seen = 0;
    prev = 3'b000;
    pat = {5'b11100, 5'b00111, 5'b11011};
    do_reset(2);
    req = 3'b111;
    for (int c = 0; c < 44; c++) begin
      step();
      vectors++;
      if ({gnt, tick, leds_obs} !== {exp_gnt, exp_tick, m_leds}) begin
        miscompares++;
        $display("FAIL rr_model cyc=%0d gnt/tick/led got %b/%b/%b want %b/%b/%b",
                 c, gnt, tick, leds_obs, exp_gnt, exp_tick, m_leds);
      end
      if (c > 0) begin
        vectors++;
        if (gnt === 3'b000) begin
          miscompares++;
          $display("FAIL rr_gap cyc=%0d gnt got 000 want nonzero", c);
        end
      end
      if (gnt !== prev && n_seen < 4) begin
        seen[n_seen] = gnt;
        n_seen++;
        $display("rr: cyc=%0d grant -> %b", c, gnt);
      end
      prev = gnt;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= n_seen || seen[i] !== want[i]) begin
        miscompares++;
        $display("FAIL rr_order idx=%0d got %b want %b", i, (i < n_seen) ? seen[i] : 3'bxxx, want[i]);
      end
    end
  endtask

  task automatic test_release();
    int guard;
    pat = {5'b10001, 5'b01110, 5'b11111};
    do_reset(2);
    req = 3'b101;
    guard = 0;
    while (!(m_owner == 0 && m_hold == 1) && guard < 100) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL release_wait: owner0 hold1 not reached in %0d cycles", guard);
    end
    req = 3'b100;
    step();
    vectors++;
    if (gnt !== 3'b000 || leds_obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL release_idle: gnt/led got %b/%b want 000/00000", gnt, leds_obs);
    end
    step();
    vectors++;
    if (gnt !== 3'b100) begin
      miscompares++;
      $display("FAIL release_next: gnt got %b want 100", gnt);
    end
    step();
    vectors++;
    if (leds_obs !== 5'b10001) begin
      miscompares++;
      $display("FAIL release_led: led got %b want 10001", leds_obs);
    end
    $display("release: handover to gnt=%b leds=%b", gnt, leds_obs);
  endtask

  task automatic test_simultaneous();
    int         guard;
    int         old_owner;
    logic [2:0] want;
    pat = {5'b00011, 5'b00110, 5'b01100};
    do_reset(2);
    req = 3'b111;
    guard = 0;
    while (!(m_owner >= 0 && m_hold == 2 && tick_at(m_cyc)) && guard < 100) begin
      step();
      guard++;
    end
    vectors++;
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL simul_wait: preempt tick not reached in %0d cycles", guard);
    end
    old_owner = (m_owner < 0) ? 0 : m_owner;
    req = 3'b111 & ~3'(1 << old_owner);
    step();
    vectors++;
    if (gnt !== 3'b000) begin
      miscompares++;
      $display("FAIL simul_idle: gnt got %b want 000", gnt);
    end
    step();
    want = 3'(1 << ((old_owner + 1) % N));
    vectors++;
    if (gnt !== want) begin
      miscompares++;
      $display("FAIL simul_rearb: gnt got %b want %b", gnt, want);
    end
    $display("simultaneous: owner %0d released on tick, regrant %b", old_owner, gnt);
  endtask

  task automatic test_tick_no_contention();
    int  ticks;
    logic prev_tick;
    pat = {5'b00000, 5'b00000, 5'b10110};
    do_reset(2);
    req = 3'b001;
    ticks = 0;
    prev_tick = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      step();
      vectors++;
      if ({gnt, tick, leds_obs} !== {exp_gnt, exp_tick, m_leds} || gnt !== 3'b001) begin
        miscompares++;
        $display("FAIL tick_model cyc=%0d gnt/tick/led got %b/%b/%b want 001/%b/%b",
                 c, gnt, tick, leds_obs, exp_tick, m_leds);
      end
      vectors++;
      if (tick === 1'b1 && prev_tick === 1'b1) begin
        miscompares++;
        $display("FAIL tick_width cyc=%0d tick high two cycles, want one", c);
      end
      if (tick === 1'b1) ticks++;
      prev_tick = tick;
    end
    vectors++;
    if (ticks != 10) begin
      miscompares++;
      $display("FAIL tick_count got %0d want 10", ticks);
    end
    $display("tick: %0d ticks, gnt held %b", ticks, gnt);
  endtask

  task automatic test_random();
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) req = 3'($urandom);
      pat = 15'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step();
      vectors++;
      if ({gnt, tick, leds_obs} !== {exp_gnt, exp_tick, m_leds}) begin
        miscompares++;
        $display("FAIL random cyc=%0d gnt/tick/led got %b/%b/%b want %b/%b/%b",
                 c, gnt, tick, leds_obs, exp_gnt, exp_tick, m_leds);
      end
    end
    rst = 1'b0;
    $display("random: 1500 cycles applied");
  endtask

  initial begin
    #2;
    test_reset();
    test_single_req();
    test_round_robin();
    test_release();
    test_simultaneous();
    test_tick_no_contention();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
